// File: rtl/adder_sched_pkg.sv
// Shared sizing helpers for the round-robin vector-sum scheduler.
// Pipeline depth, requester-ID width and counter widths all derive from the top-level parameters.
package adder_sched_pkg;

    function automatic int calc_lat(input int num);
        return $clog2(num);
    endfunction

    function automatic int calc_id_w(input int req_n);
        return (req_n > 1) ? $clog2(req_n) : 1;
    endfunction

    // Counters must represent the full depth value, not just depth-1.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int calc_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/adder_sched_tree.sv
// Pipelined binary adder tree: one register level per tree level, latency $clog2(pDAT_Num).
// Heap-indexed nodes: node i sums nodes 2i and 2i+1; indices >= pDAT_Num are the input samples.
module adder_sched_tree
    import adder_sched_pkg::*;
#(
    parameter int pDAT_W   = 12,
    parameter int pDAT_Num = 2048
) (
    input  logic                              iclk,
    input  logic                              iena,
    input  logic [pDAT_Num-1:0][pDAT_W-1:0]   idat,
    output logic signed [pDAT_W-1:0]          odat
);

    function automatic logic signed [pDAT_W-1:0] add_wrap(
        input logic signed [pDAT_W-1:0] a,
        input logic signed [pDAT_W-1:0] b
    );
        return a + b;
    endfunction

    logic signed [pDAT_W-1:0] node [1:pDAT_Num-1];

    for (genvar i = 1; i < pDAT_Num; i++) begin : g_node
        logic signed [pDAT_W-1:0] sum_q;

        // Only the input level is gated; upper levels free-run and validity is tracked outside.
        if (2 * i >= pDAT_Num) begin : g_leaf
            always_ff @(posedge iclk) begin
                if (iena) begin
                    sum_q <= add_wrap(idat[2*i-pDAT_Num], idat[2*i+1-pDAT_Num]);
                end
            end
        end else begin : g_inner
            always_ff @(posedge iclk) begin
                sum_q <= add_wrap(node[2*i], node[2*i+1]);
            end
        end

        assign node[i] = sum_q;
    end

    assign odat = node[1];

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one pipelined adder tree among pREQ_N vector requesters.
// Credit accounting reserves FIFO space at launch, so results can never be dropped.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int pDAT_W   = 12,
    parameter int pDAT_Num = 2048,
    parameter int pREQ_N   = 4,
    parameter int pFIFO_D  = 8
) (
    input  logic                                          iclk,
    input  logic                                          irst_n,
    input  logic [pREQ_N-1:0]                             ireq_val,
    input  logic signed [pREQ_N-1:0][pDAT_Num-1:0][pDAT_W-1:0] idat,
    output logic [pREQ_N-1:0]                             oreq_rdy,
    output logic                                          ores_val,
    output logic signed [pDAT_W-1:0]                      ores_dat,
    output logic [$clog2(pREQ_N)-1:0]                     ores_id,
    input  logic                                          ires_rdy,
    output logic                                          obusy
);

    localparam int cLAT   = calc_lat(pDAT_Num);
    localparam int cID_W  = calc_id_w(pREQ_N);
    localparam int cCNT_W = calc_cnt_w(pFIFO_D);
    localparam int cPTR_W = calc_ptr_w(pFIFO_D);
    localparam logic [cCNT_W:0] cDEPTH = (cCNT_W + 1)'(pFIFO_D);

    typedef struct packed {
        logic [cID_W-1:0]         id;
        logic signed [pDAT_W-1:0] dat;
    } fifo_entry_t;

    function automatic logic [cID_W-1:0] rr_index(
        input logic [cID_W-1:0] base,
        input int               offset
    );
        int c;
        c = int'(base) + 1 + offset;
        if (c >= pREQ_N) c -= pREQ_N;
        return c[cID_W-1:0];
    endfunction

    function automatic logic [cPTR_W-1:0] ptr_inc(input logic [cPTR_W-1:0] p);
        return (p == cPTR_W'(pFIFO_D - 1)) ? '0 : p + cPTR_W'(1);
    endfunction

    logic [cID_W-1:0]         last_grant_q, last_grant_d;
    logic [cID_W-1:0]         grant_idx;
    logic                     grant_found;
    logic                     have_credit;
    logic                     accept;
    logic [cCNT_W:0]          occupancy;

    logic [cCNT_W-1:0]        inflight_q, inflight_d;
    logic [cLAT-1:0]          sr_vld_q;
    logic [cID_W-1:0]         sr_id_q [cLAT];
    logic                     sr_out_vld;
    logic [cID_W-1:0]         sr_out_id;

    logic signed [pDAT_W-1:0] tree_sum;

    fifo_entry_t              fifo_mem_q [pFIFO_D];
    fifo_entry_t              fifo_head;
    logic [cPTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [cPTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [cCNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                     fifo_empty;
    logic                     fifo_wr;
    logic                     fifo_rd;

    // Arbitration: search from last_grant+1 and wrap; launch only with reserved FIFO space.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < pREQ_N; k++) begin
            if (!grant_found && ireq_val[rr_index(last_grant_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(last_grant_q, k);
            end
        end
    end

    assign occupancy   = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign have_credit = occupancy < cDEPTH;
    assign accept      = irst_n & grant_found & have_credit;

    always_comb begin
        oreq_rdy            = '0;
        oreq_rdy[grant_idx] = accept;
    end

    assign last_grant_d = accept ? grant_idx : last_grant_q;

    adder_sched_tree #(
        .pDAT_W   (pDAT_W),
        .pDAT_Num (pDAT_Num)
    ) u_adder (
        .iclk (iclk),
        .iena (accept),
        .idat (idat[grant_idx]),
        .odat (tree_sum)
    );

    // Launch tracking: {valid, id} walks alongside the tree and emerges with its sum.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sr_vld_q <= '0;
            for (int k = 0; k < cLAT; k++) sr_id_q[k] <= '0;
        end else begin
            sr_vld_q[0] <= accept;
            sr_id_q[0]  <= grant_idx;
            for (int k = 1; k < cLAT; k++) begin
                sr_vld_q[k] <= sr_vld_q[k-1];
                sr_id_q[k]  <= sr_id_q[k-1];
            end
        end
    end

    assign sr_out_vld = sr_vld_q[cLAT-1];
    assign sr_out_id  = sr_id_q[cLAT-1];

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, sr_out_vld})
            2'b10:   inflight_d = inflight_q + cCNT_W'(1);
            2'b01:   inflight_d = inflight_q - cCNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Result FIFO: show-ahead, head read combinationally from storage.
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_wr    = sr_out_vld;
    assign fifo_rd    = !fifo_empty & ires_rdy;
    assign wr_ptr_d   = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d   = fifo_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_cnt_d = fifo_cnt_q + cCNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - cCNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q] <= '{id: sr_out_id, dat: tree_sum};
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            last_grant_q <= cID_W'(pREQ_N - 1);
            inflight_q   <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Zero the outputs while empty so unwritten storage never leaks out, including in reset.
    assign fifo_head = fifo_mem_q[rd_ptr_q];
    assign ores_val  = !fifo_empty;
    assign ores_dat  = fifo_empty ? '0 : fifo_head.dat;
    assign ores_id   = fifo_empty ? '0 : fifo_head.id;
    assign obusy     = (inflight_q != '0) | !fifo_empty;

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched: vector table, round-robin, backpressure, streaming and reset.
// A scoreboard records every launch and checks every consumed result in order.
module tb_adder_sched;

    localparam int W = 12;
    localparam int N = 8;
    localparam int R = 4;
    localparam int D = 4;

    logic                             iclk = 1'b0;
    logic                             irst_n;
    logic [R-1:0]                     ireq_val;
    logic signed [R-1:0][N-1:0][W-1:0] idat;
    logic [R-1:0]                     oreq_rdy;
    logic                             ores_val;
    logic signed [W-1:0]              ores_dat;
    logic [1:0]                       ores_id;
    logic                             ires_rdy;
    logic                             obusy;

    adder_sched #(
        .pDAT_W   (W),
        .pDAT_Num (N),
        .pREQ_N   (R),
        .pFIFO_D  (D)
    ) dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .ireq_val (ireq_val),
        .idat     (idat),
        .oreq_rdy (oreq_rdy),
        .ores_val (ores_val),
        .ores_dat (ores_dat),
        .ores_id  (ores_id),
        .ires_rdy (ires_rdy),
        .obusy    (obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int id;
        int dat;
    } exp_t;

    typedef struct {
        int req;
        int base;
        int step;
        int exp;
    } vec_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_pop = 0;
    logic         s_acc;
    int           s_acc_id;
    logic         s_val;
    logic         s_busy;
    logic [R-1:0] s_rdy;
    int           s_dat;
    int           s_id;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int vec_sum(input int k);
        int s;
        logic signed [W-1:0] t;
        s = 0;
        for (int j = 0; j < N; j++) s += int'($signed(idat[k][j]));
        t = s[W-1:0];
        return int'(t);
    endfunction

    task automatic sb_step();
        exp_t e;
        s_rdy  = oreq_rdy;
        s_val  = ores_val;
        s_dat  = int'(ores_dat);
        s_id   = int'(ores_id);
        s_busy = obusy;
        s_acc  = 1'b0;
        if (irst_n) begin
            check("rdy_onehot", int'($countones(oreq_rdy) <= 1), 1);
            check("rdy_subset", int'((oreq_rdy & ~ireq_val) == '0), 1);
            for (int k = 0; k < R; k++) begin
                if (oreq_rdy[k] && ireq_val[k]) begin
                    s_acc    = 1'b1;
                    s_acc_id = k;
                    n_acc++;
                    sb_q.push_back('{k, vec_sum(k)});
                end
            end
            if (ores_val && ires_rdy) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id %0d dat %0d, expected none", s_id, s_dat);
                end else begin
                    e = sb_q.pop_front();
                    check("res_dat", s_dat, e.dat);
                    check("res_id", s_id, e.id);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge iclk);
        cyc++;
        sb_step();
        @(posedge iclk);
        #1;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            tick();
            if (!s_busy && !s_val && sb_q.size() == 0) idle = 1'b1;
        end
        check("idle_timeout", int'(idle), 1);
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        sb_q.delete();
        tick();
        tick();
        irst_n = 1'b1;
    endtask

    vec_t vecs[6];
    int   gseq[6];
    int   gcyc[6];
    int   ng;
    int   t_acc;
    int   cnt;
    int   acc0;
    int   pop0;
    logic got;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1, 0, 8};
        vecs[1] = '{2, 2047, 0, -8};
        vecs[2] = '{2, -2048, 0, 0};
        vecs[3] = '{3, 0, 1, 28};
        vecs[4] = '{0, 100, 100, -496};
        vecs[5] = '{1, -1000, 100, -1104};

        irst_n   = 1'b0;
        ireq_val = 4'b0001;
        idat     = '0;
        ires_rdy = 1'b1;
        repeat (3) @(posedge iclk);
        #1;
        check("rst_oreq_rdy", int'(oreq_rdy), 0);
        check("rst_ores_val", int'(ores_val), 0);
        check("rst_obusy", int'(obusy), 0);
        check("rst_ores_dat", int'(ores_dat), 0);
        check("rst_ores_id", int'(ores_id), 0);

        // First cycle out of reset must already accept.
        irst_n = 1'b1;
        tick();
        check("first_cycle_accept", int'(s_rdy), 1);
        ireq_val = '0;
        wait_idle();

        // Table of single-launch vectors: value, id and launch-to-valid latency.
        foreach (vecs[v]) begin
            idat = '0;
            for (int j = 0; j < N; j++) idat[vecs[v].req][j] = W'(vecs[v].base + vecs[v].step * j);
            ireq_val = 4'(1 << vecs[v].req);
            got = 1'b0;
            t_acc = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (s_acc) begin
                    got = 1'b1;
                    t_acc = cyc;
                end
            end
            check($sformatf("vec%0d_accept", v), int'(got), 1);
            ireq_val = '0;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (s_val) got = 1'b1;
            end
            check($sformatf("vec%0d_result", v), int'(got), 1);
            check($sformatf("vec%0d_latency", v), cyc - t_acc, 4);
            check($sformatf("vec%0d_dat", v), s_dat, vecs[v].exp);
            check($sformatf("vec%0d_id", v), s_id, vecs[v].req);
            wait_idle();
        end

        // Round-robin from a fresh reset: requester 0 first, then rotate.
        do_reset();
        for (int k = 0; k < R; k++)
            for (int j = 0; j < N; j++) idat[k][j] = W'(k + 1);
        ireq_val = 4'hF;
        ng = 0;
        for (int i = 0; i < 40 && ng < 6; i++) begin
            tick();
            if (s_acc) begin
                gseq[ng] = s_acc_id;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        ireq_val = '0;
        check("rr_grant_count", ng, 6);
        for (int i = 0; i < ng; i++) check($sformatf("rr_grant%0d", i), gseq[i], i % R);
        for (int i = 1; i < 4 && i < ng; i++) check($sformatf("rr_consecutive%0d", i), gcyc[i] - gcyc[i-1], 1);
        wait_idle();

        // Backpressure: credit limits launches to the FIFO depth.
        ires_rdy = 1'b0;
        ireq_val = 4'hF;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_acc) cnt++;
        end
        check("bp_accepts", cnt, D);
        check("bp_rdy_low", int'(s_rdy), 0);
        ires_rdy = 1'b1;
        cnt = 0;
        tick();
        if (s_acc) cnt++;
        ires_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_acc) cnt++;
        end
        check("bp_one_more", cnt, 1);
        ireq_val = '0;
        ires_rdy = 1'b1;
        wait_idle();

        // Random streaming: simultaneous FIFO reads/writes across all fill levels.
        acc0 = n_acc;
        pop0 = n_pop;
        for (int i = 0; i < 120; i++) begin
            ireq_val = 4'($urandom_range(0, 15));
            ires_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < R; k++)
                for (int j = 0; j < N; j++) idat[k][j] = W'($urandom);
            tick();
        end
        ireq_val = '0;
        ires_rdy = 1'b1;
        wait_idle();
        check("stream_no_loss", n_pop - pop0, n_acc - acc0);
        check("stream_sb_empty", sb_q.size(), 0);

        // Reset with results queued and launches in flight.
        ires_rdy = 1'b0;
        ireq_val = 4'hF;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_val", int'(s_val), 1);
        check("pre_reset_busy", int'(s_busy), 1);
        irst_n = 1'b0;
        #1;
        check("mid_rst_ores_val", int'(ores_val), 0);
        check("mid_rst_obusy", int'(obusy), 0);
        check("mid_rst_oreq_rdy", int'(oreq_rdy), 0);
        sb_q.delete();
        ireq_val = '0;
        tick();
        tick();
        irst_n = 1'b1;
        ires_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_val || s_busy) cnt++;
        end
        check("post_rst_no_stale", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
